// File: rtl/gaussian_row_feeder_pkg.sv
// Shared constants for the Gaussian filter row feeder: ring geometry,
// read-side state encoding and the ring index type.
package gaussian_row_feeder_pkg;

    localparam int GF_WORDS_PER_ROW = 64;
    localparam int GF_RING_DEPTH    = 4;
    localparam int GF_ADDR_W        = $clog2(GF_WORDS_PER_ROW);

    localparam logic [1:0] GF_IDLE   = 2'd0;
    localparam logic [1:0] GF_PUSH   = 2'd1;
    localparam logic [1:0] GF_DRAIN  = 2'd2;
    localparam logic [1:0] GF_FILTER = 2'd3;

    // Ring index; 2 bits so increments wrap mod GF_RING_DEPTH for free.
    typedef logic [1:0] gf_buf_t;

endpackage

// File: rtl/gaussian_row_feeder_row_ram.sv
// One row buffer of the ring: simple dual-port RAM, one write port and
// one registered read port (1-cycle read latency).
module gf_row_ram
    import gaussian_row_feeder_pkg::*;
#(
    parameter int DEPTH  = GF_WORDS_PER_ROW,
    parameter int ADDR_W = GF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [63:0]       wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [63:0]       rd_data_o
);

    logic [63:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset so it can map onto block RAM;
    // its contents are don't-care until a row has been written.
    always_ff @(posedge i_clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/gaussian_row_feeder.sv
// Row feeder for the Gaussian filter: buffers incoming rows in a 4-entry
// ring and pushes three consecutive rows in parallel for each filter pass.
module gaussian_row_feeder
    import gaussian_row_feeder_pkg::*;
#(
    parameter int WORDS_PER_ROW = GF_WORDS_PER_ROW,
    parameter int IMG_ROWS      = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_data_valid,
    input  logic [63:0] i_data,
    output logic        o_data_ack,
    output logic        o_line1_data_valid,
    output logic        o_line2_data_valid,
    output logic        o_line3_data_valid,
    output logic [63:0] o_line1_data,
    output logic [63:0] o_line2_data,
    output logic [63:0] o_line3_data,
    input  logic        i_line1_data_ack,
    input  logic        i_line2_data_ack,
    input  logic        i_line3_data_ack,
    output logic        o_filter,
    input  logic        i_row_done,
    output logic        o_frame_done
);

    localparam int ADDR_W = $clog2(WORDS_PER_ROW);
    localparam int ROW_W  = $clog2(IMG_ROWS + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(WORDS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  ROWS_FULL   = ROW_W'(IMG_ROWS);
    localparam logic [ROW_W-1:0]  PASSES_FULL = ROW_W'(IMG_ROWS - 2);
    localparam logic [2:0]        RING_FULL   = 3'(GF_RING_DEPTH);

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] wcnt_q,    wcnt_d;
    logic [ADDR_W-1:0] raddr_q,   raddr_d;
    logic [ROW_W-1:0]  rows_in_q, rows_in_d;
    logic [ROW_W-1:0]  passes_q,  passes_d;
    logic [2:0]        stored_q,  stored_d;
    gf_buf_t           wbuf_q,    wbuf_d;
    gf_buf_t           rbuf_q,    rbuf_d;
    logic              line_valid_q;
    logic              frame_done_q, frame_done_d;

    logic    wr_accept;
    logic    row_wr_done;
    logic    release_row;
    logic    frame_clear;
    gf_buf_t rbuf_p1;
    gf_buf_t rbuf_p2;
    logic [63:0] ram_rd_data [GF_RING_DEPTH];

    // Destination line buffers always accept, so their acks carry no information.
    logic unused_line_acks;
    assign unused_line_acks = i_line1_data_ack & i_line2_data_ack & i_line3_data_ack;

    assign o_data_ack  = (stored_q < RING_FULL) && (rows_in_q < ROWS_FULL);
    assign wr_accept   = i_data_valid && o_data_ack;
    assign row_wr_done = wr_accept && (wcnt_q == LAST_ADDR);

    // NOTE: every _d signal gets its hold value first, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        raddr_d      = raddr_q;
        passes_d     = passes_q;
        rbuf_d       = rbuf_q;
        frame_done_d = 1'b0;
        release_row  = 1'b0;
        frame_clear  = 1'b0;
        wcnt_d       = wr_accept   ? wcnt_q + 1'b1    : wcnt_q;
        wbuf_d       = row_wr_done ? wbuf_q + 2'd1    : wbuf_q;
        rows_in_d    = row_wr_done ? rows_in_q + 1'b1 : rows_in_q;

        case (state_q)
            GF_IDLE: begin
                if (passes_q == PASSES_FULL && rows_in_q == ROWS_FULL) begin
                    frame_done_d = 1'b1;
                    frame_clear  = 1'b1;
                end else if (stored_q >= 3'd3) begin
                    state_d = GF_PUSH;
                    raddr_d = '0;
                end
            end
            GF_PUSH: begin
                raddr_d = raddr_q + 1'b1;
                if (raddr_q == LAST_ADDR) begin
                    state_d = GF_DRAIN;
                end
            end
            GF_DRAIN: state_d = GF_FILTER;
            GF_FILTER: begin
                if (i_row_done) begin
                    release_row = 1'b1;
                    rbuf_d      = rbuf_q + 2'd1;
                    passes_d    = passes_q + 1'b1;
                    state_d     = GF_IDLE;
                end
            end
            default: state_d = GF_IDLE;
        endcase

        // A row landing and a row being released in the same cycle cancel out.
        stored_d = stored_q + {2'b00, row_wr_done} - {2'b00, release_row};

        // The two rows left in the ring at frame end are simply forgotten.
        if (frame_clear) begin
            rows_in_d = '0;
            passes_d  = '0;
            stored_d  = '0;
            wbuf_d    = '0;
            rbuf_d    = '0;
        end
    end

    // NOTE: state registers take non-blocking assignments only; all
    // next-state arithmetic lives in the combinational block above.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= GF_IDLE;
            wcnt_q       <= '0;
            raddr_q      <= '0;
            rows_in_q    <= '0;
            passes_q     <= '0;
            stored_q     <= '0;
            wbuf_q       <= '0;
            rbuf_q       <= '0;
            line_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            raddr_q      <= raddr_d;
            rows_in_q    <= rows_in_d;
            passes_q     <= passes_d;
            stored_q     <= stored_d;
            wbuf_q       <= wbuf_d;
            rbuf_q       <= rbuf_d;
            line_valid_q <= (state_q == GF_PUSH);
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar g = 0; g < GF_RING_DEPTH; g++) begin : g_ring
        gf_row_ram #(
            .DEPTH  (WORDS_PER_ROW),
            .ADDR_W (ADDR_W)
        ) u_row_ram (
            .i_clk     (i_clk),
            .wr_en_i   (wr_accept && (wbuf_q == gf_buf_t'(g))),
            .wr_addr_i (wcnt_q),
            .wr_data_i (i_data),
            .rd_addr_i (raddr_q),
            .rd_data_o (ram_rd_data[g])
        );
    end

    // rbuf is stable across PUSH and DRAIN, so the mux can use it unregistered.
    assign rbuf_p1 = rbuf_q + 2'd1;
    assign rbuf_p2 = rbuf_q + 2'd2;

    assign o_line1_data       = ram_rd_data[rbuf_q];
    assign o_line2_data       = ram_rd_data[rbuf_p1];
    assign o_line3_data       = ram_rd_data[rbuf_p2];
    assign o_line1_data_valid = line_valid_q;
    assign o_line2_data_valid = line_valid_q;
    assign o_line3_data_valid = line_valid_q;
    assign o_filter           = (state_q == GF_FILTER);
    assign o_frame_done       = frame_done_q;

endmodule

// File: tb/tb_gaussian_row_feeder.sv
// Directed bench for gaussian_row_feeder: words carry {row, addr} with a
// global row number, so every pushed line identifies its source row.
module tb_gaussian_row_feeder;

    localparam int W = 64;
    localparam int R = 5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_data_valid;
    logic [63:0] i_data;
    logic        o_data_ack;
    logic        o_line1_data_valid, o_line2_data_valid, o_line3_data_valid;
    logic [63:0] o_line1_data, o_line2_data, o_line3_data;
    logic        i_row_done = 1'b0;
    logic        o_filter;
    logic        o_frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int src_cnt  = 0;
    int src_limit = 544;
    int acc191   = -1;
    bit src_en   = 1'b0;
    bit src_pend = 1'b0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    gaussian_row_feeder #(
        .WORDS_PER_ROW (W),
        .IMG_ROWS      (R)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_data_valid       (i_data_valid),
        .i_data             (i_data),
        .o_data_ack         (o_data_ack),
        .o_line1_data_valid (o_line1_data_valid),
        .o_line2_data_valid (o_line2_data_valid),
        .o_line3_data_valid (o_line3_data_valid),
        .o_line1_data       (o_line1_data),
        .o_line2_data       (o_line2_data),
        .o_line3_data       (o_line3_data),
        .i_line1_data_ack   (1'b1),
        .i_line2_data_ack   (1'b1),
        .i_line3_data_ack   (1'b1),
        .o_filter           (o_filter),
        .i_row_done         (i_row_done),
        .o_frame_done       (o_frame_done)
    );

    function automatic logic [63:0] row_word(input int row, input int addr);
        return {32'(row), 32'(addr)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Source: streams word n = {n / W, n % W}; acceptance is decided from the
    // registered ack, which is stable for the whole low phase of the clock.
    initial begin
        i_data_valid = 1'b0;
        i_data       = '0;
        forever begin
            @(negedge i_clk);
            #1;
            if (src_pend) src_cnt++;
            if (src_en && src_cnt < src_limit) begin
                i_data_valid = 1'b1;
                i_data       = row_word(src_cnt / W, src_cnt % W);
            end else begin
                i_data_valid = 1'b0;
            end
            src_pend = i_data_valid && o_data_ack && i_rst;
            if (src_pend && src_cnt == 191) acc191 = cyc + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_push(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge i_clk);
            seen = o_line1_data_valid;
        end
        check({tag, "_start"}, 64'(seen), 64'd1);
    endtask

    // Called on the first valid cycle; walks n_words words of the push.
    task automatic check_words(input string tag, input int base, input int n_words);
        int bad = 0;
        check({tag, "_line3_w0"}, o_line3_data, row_word(base + 2, 0));
        for (int k = 0; k < n_words; k++) begin
            if (k != 0) @(negedge i_clk);
            if ({o_line1_data_valid, o_line2_data_valid, o_line3_data_valid} !== 3'b111 ||
                o_line1_data !== row_word(base, k) ||
                o_line2_data !== row_word(base + 1, k) ||
                o_line3_data !== row_word(base + 2, k)) bad++;
        end
        check({tag, "_words"}, 64'(bad), 64'd0);
    endtask

    task automatic check_filter(input string tag);
        @(negedge i_clk);
        check({tag, "_filter_rise"}, 64'({o_line1_data_valid, o_filter}), 64'd1);
        repeat (6) @(negedge i_clk);
        check({tag, "_filter_hold"}, 64'(o_filter), 64'd1);
    endtask

    task automatic pulse_row_done(input string tag);
        i_row_done = 1'b1;
        @(negedge i_clk);
        i_row_done = 1'b0;
        check({tag, "_filter_fall"}, 64'(o_filter), 64'd0);
    endtask

    initial begin
        bit aligned;

        // Reset and the first idle cycle.
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        check("rst_ack", 64'(o_data_ack), 64'd1);
        check("rst_outputs", 64'({o_line1_data_valid, o_line2_data_valid, o_line3_data_valid,
                                  o_filter, o_frame_done}), 64'd0);
        i_row_done = 1'b1;
        @(negedge i_clk);
        i_row_done = 1'b0;
        check("idle_done_ignored", 64'({dut.passes_q, dut.rbuf_q}), 64'd0);
        src_en = 1'b1;

        // Frame 0, pass 0: steady fill, then the ring fills up behind it.
        wait_push("f0p0");
        check("f0p0_latency", 64'(cyc), 64'(acc191 + 2));
        check_words("f0p0", 0, W);
        check_filter("f0p0");
        check("full_ack_low", 64'(o_data_ack), 64'd0);
        check("full_word_count", 64'(src_cnt), 64'd256);
        pulse_row_done("f0p0");
        check("release_ack", 64'(o_data_ack), 64'd1);

        // Frame 0, passes 1 and 2: rotation and reuse of buffer 0 for row 4.
        wait_push("f0p1");
        check_words("f0p1", 1, W);
        check_filter("f0p1");
        pulse_row_done("f0p1");
        wait_push("f0p2");
        check_words("f0p2", 2, W);
        check_filter("f0p2");
        check("rows_cap_ack", 64'(o_data_ack), 64'd0);
        check("rows_cap_count", 64'(src_cnt), 64'd320);
        pulse_row_done("f0p2");
        check("frame_done_early", 64'(o_frame_done), 64'd0);
        @(negedge i_clk);
        check("frame_done_pulse", 64'(o_frame_done), 64'd1);
        check("wrap_counters", 64'({dut.rows_in_q, dut.passes_q, dut.stored_q,
                                    dut.wbuf_q, dut.rbuf_q}), 64'd0);
        check("wrap_ack", 64'(o_data_ack), 64'd1);
        @(negedge i_clk);
        check("frame_done_single", 64'(o_frame_done), 64'd0);

        // Frame 1 (global rows 5..9); the source pauses mid row 8.
        wait_push("f1p0");
        check_words("f1p0", 5, W);
        check_filter("f1p0");
        check("partial_ack", 64'(o_data_ack), 64'd1);
        check("partial_count", 64'(src_cnt), 64'd544);

        // Release a row in the same cycle the last word of row 8 lands.
        src_limit = 1 << 30;
        aligned = 1'b0;
        for (int i = 0; i < 200 && !aligned; i++) begin
            @(negedge i_clk);
            #2;
            aligned = i_data_valid && o_data_ack && (i_data[31:0] == 32'd63);
        end
        check("sim_aligned", 64'(aligned), 64'd1);
        check("sim_stored_before", 64'(dut.stored_q), 64'd3);
        i_row_done = 1'b1;
        @(negedge i_clk);
        i_row_done = 1'b0;
        check("sim_stored_after", 64'(dut.stored_q), 64'd3);
        check("sim_filter_fall", 64'(o_filter), 64'd0);

        wait_push("f1p1");
        check_words("f1p1", 6, W);
        check_filter("f1p1");
        pulse_row_done("f1p1");

        // Frame 1, pass 2: reset lands while raddr is 30.
        wait_push("f1p2");
        check_words("f1p2", 7, 30);
        i_rst  = 1'b0;
        src_en = 1'b0;
        @(negedge i_clk);
        check("midrst_outputs", 64'({o_line1_data_valid, o_line2_data_valid, o_line3_data_valid,
                                     o_filter, o_frame_done}), 64'd0);
        check("midrst_ack", 64'(o_data_ack), 64'd1);
        repeat (2) @(negedge i_clk);
        src_cnt = 16 * W;
        i_rst   = 1'b1;
        src_en  = 1'b1;

        // Fresh frame starting at global row 16.
        wait_push("f2p0");
        check_words("f2p0", 16, W);
        check_filter("f2p0");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
